// File: rtl/cfi_mailbox_pkg.sv
// CFI log mailbox shared types: AXI4 channel bundles, FSM states
// and the mailbox address defaults shared with the CFI stage.
package cfi_mailbox_pkg;

    localparam int unsigned AXI_ID_W = 4;

    localparam logic [63:0] CFI_MBOX_ADDR      = 64'h1040_4000;
    localparam logic [63:0] CFI_MBOX_DB_ADDR   = 64'h1040_4020;
    localparam int unsigned CFI_MBOX_XFER_SIZE = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [63:0]         addr;
        logic [7:0]          len;
        logic [5:0]          atop;
    } axi_aw_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [63:0]         addr;
        logic [7:0]          len;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [63:0]         data;
        logic [1:0]          resp;
        logic                last;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_resp_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_DATA,
        W_DB_WAIT,
        W_RESP,
        W_DRAIN
    } cfi_mbox_wstate_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } cfi_mbox_rstate_e;

endpackage

// File: rtl/cfi_mailbox_buffer.sv
// Byte-strobed 64-bit word array: one write port, one async read
// port and the whole array as a flat vector (word 0 in the LSBs).
module cfi_mailbox_buffer #(
    parameter int unsigned WORDS = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [63:0]           wdata_i,
    input  logic [7:0]            wstrb_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [63:0]           rdata_o,
    output logic [WORDS*64-1:0]   flat_o
);

    logic [63:0] mem [WORDS];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                mem[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < 8; b++) begin
                if (wstrb_i[b]) begin
                    mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem[raddr_i];

    for (genvar g = 0; g < int'(WORDS); g++) begin : g_flat
        assign flat_o[64*g +: 64] = mem[g];
    end

endmodule

// File: rtl/cfi_mailbox.sv
// CFI log mailbox: AXI4 slave buffering one record and publishing it
// on a valid/ready port when the doorbell is written.
module cfi_mailbox
    import cfi_mailbox_pkg::*;
#(
    parameter logic [63:0] MAILBOX_ADDR    = CFI_MBOX_ADDR,
    parameter logic [63:0] MAILBOX_DB_ADDR = CFI_MBOX_DB_ADDR,
    parameter int unsigned XFER_SIZE       = CFI_MBOX_XFER_SIZE
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  axi_req_t               axi_req_i,
    output axi_resp_t              axi_resp_o,
    output logic [XFER_SIZE*8-1:0] msg_o,
    output logic                   msg_valid_o,
    input  logic                   msg_ready_i,
    output logic                   irq_o
);

    localparam int unsigned WORDS = XFER_SIZE / 8;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [63:0] WIN_BYTES = 64'(XFER_SIZE);

    cfi_mbox_wstate_e wstate;
    cfi_mbox_rstate_e rstate;

    logic [AXI_ID_W-1:0] aw_id;
    logic [63:0]         aw_addr;
    logic                aw_bad;
    logic [1:0]          b_resp;
    logic [AXI_ID_W-1:0] r_id;
    logic [63:0]         r_data;
    logic [1:0]          r_resp;

    logic [XFER_SIZE*8-1:0] msg_q;
    logic                   msg_valid_q;

    logic [63:0]            buf_rdata;
    logic [XFER_SIZE*8-1:0] buf_flat;
    logic                   buf_we;

    logic [63:0]      w_off;
    logic [63:0]      r_off;
    logic             w_win;
    logic             w_db;
    logic             r_win;
    logic             r_db;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] r_idx;

    assign w_off = aw_addr - MAILBOX_ADDR;
    assign w_win = w_off < WIN_BYTES;
    assign w_db  = (aw_addr >> 3) == (MAILBOX_DB_ADDR >> 3);
    assign w_idx = w_off[IDX_W+2:3];

    assign r_off = axi_req_i.ar.addr - MAILBOX_ADDR;
    assign r_win = r_off < WIN_BYTES;
    assign r_db  = (axi_req_i.ar.addr >> 3) == (MAILBOX_DB_ADDR >> 3);
    assign r_idx = r_off[IDX_W+2:3];

    logic aw_ready;
    logic w_ready;
    logic ar_ready;
    logic w_hs;

    assign aw_ready = rst_ni && (wstate == W_IDLE);
    assign w_ready  = rst_ni && (wstate == W_DATA || wstate == W_DRAIN);
    assign ar_ready = rst_ni && (rstate == R_IDLE);
    assign w_hs     = w_ready && axi_req_i.w_valid;

    // Mutually exclusive decode of the single data beat.
    logic has_strb;
    logic d_bad;
    logic d_win;
    logic d_db_set;
    logic d_db_nop;

    assign has_strb = |axi_req_i.w.strb;
    assign d_bad    = aw_bad;
    assign d_win    = !aw_bad && w_win;
    assign d_db_set = !aw_bad && !w_win && w_db && has_strb;
    assign d_db_nop = !aw_bad && !w_win && w_db && !has_strb;

    assign buf_we = w_hs && (wstate == W_DATA) && d_win;

    cfi_mailbox_buffer #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_buffer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (buf_we),
        .waddr_i (w_idx),
        .wdata_i (axi_req_i.w.data),
        .wstrb_i (axi_req_i.w.strb),
        .raddr_i (r_idx),
        .rdata_o (buf_rdata),
        .flat_o  (buf_flat)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wstate      <= W_IDLE;
            aw_id       <= '0;
            aw_addr     <= '0;
            aw_bad      <= 1'b0;
            b_resp      <= AXI_RESP_OKAY;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
        end else begin
            if (msg_valid_q && msg_ready_i) begin
                msg_valid_q <= 1'b0;
            end
            unique case (wstate)
                W_IDLE: begin
                    if (axi_req_i.aw_valid) begin
                        aw_id   <= axi_req_i.aw.id;
                        aw_addr <= axi_req_i.aw.addr;
                        aw_bad  <= (axi_req_i.aw.len != 8'd0) ||
                                   (axi_req_i.aw.atop != 6'd0);
                        wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi_req_i.w_valid) begin
                        b_resp <= AXI_RESP_OKAY;
                        wstate <= W_RESP;
                        unique case (1'b1)
                            d_bad: begin
                                b_resp <= AXI_RESP_SLVERR;
                                // A single-beat illegal write has no more beats to drain.
                                if (!axi_req_i.w.last) begin
                                    wstate <= W_DRAIN;
                                end
                            end
                            d_win: ;
                            d_db_set: begin
                                if (!msg_valid_q) begin
                                    msg_q       <= buf_flat;
                                    msg_valid_q <= 1'b1;
                                end else begin
                                    wstate <= W_DB_WAIT;
                                end
                            end
                            d_db_nop: ;
                            default: b_resp <= AXI_RESP_DECERR;
                        endcase
                    end
                end
                W_DB_WAIT: begin
                    // Also covers a consumer that took the record on the doorbell beat.
                    if (!msg_valid_q || msg_ready_i) begin
                        msg_q       <= buf_flat;
                        msg_valid_q <= 1'b1;
                        wstate      <= W_RESP;
                    end
                end
                W_DRAIN: begin
                    if (axi_req_i.w_valid && axi_req_i.w.last) begin
                        wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (axi_req_i.b_ready) begin
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rstate <= R_IDLE;
            r_id   <= '0;
            r_data <= '0;
            r_resp <= AXI_RESP_OKAY;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (axi_req_i.ar_valid) begin
                        r_id   <= axi_req_i.ar.id;
                        rstate <= R_RESP;
                        unique case (1'b1)
                            (axi_req_i.ar.len != 8'd0): begin
                                r_data <= '0;
                                r_resp <= AXI_RESP_SLVERR;
                            end
                            (axi_req_i.ar.len == 8'd0) && r_win: begin
                                r_data <= buf_rdata;
                                r_resp <= AXI_RESP_OKAY;
                            end
                            (axi_req_i.ar.len == 8'd0) && !r_win && r_db: begin
                                r_data <= {63'b0, msg_valid_q};
                                r_resp <= AXI_RESP_OKAY;
                            end
                            default: begin
                                r_data <= '0;
                                r_resp <= AXI_RESP_DECERR;
                            end
                        endcase
                    end
                end
                R_RESP: begin
                    if (axi_req_i.r_ready) begin
                        rstate <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign axi_resp_o.aw_ready = aw_ready;
    assign axi_resp_o.w_ready  = w_ready;
    assign axi_resp_o.ar_ready = ar_ready;
    assign axi_resp_o.b_valid  = rst_ni && (wstate == W_RESP);
    assign axi_resp_o.b.id     = aw_id;
    assign axi_resp_o.b.resp   = b_resp;
    assign axi_resp_o.r_valid  = rst_ni && (rstate == R_RESP);
    assign axi_resp_o.r.id     = r_id;
    assign axi_resp_o.r.data   = r_data;
    assign axi_resp_o.r.resp   = r_resp;
    assign axi_resp_o.r.last   = 1'b1;

    assign msg_o       = msg_q;
    assign msg_valid_o = msg_valid_q;
    assign irq_o       = msg_valid_q;

endmodule

// File: doc/cfi_mailbox.md
# cfi_mailbox

CFI log mailbox: an AXI4 slave that receives control-flow log records written by the CFI stage's backend and hands them to the security monitor. It sits directly downstream of the CFI stage on its `cfi_axi` port. It buffers one record in a data window and publishes it on a valid/ready message port when the doorbell is written. A doorbell arriving while the previous record is still unconsumed back-pressures the writer by withholding its B response.

## Interface
- `MAILBOX_ADDR`, default 'h10404000: base of the data window, which is `XFER_SIZE` bytes long and 8-byte aligned.
- `MAILBOX_DB_ADDR`, default 'h10404020: doorbell register address. It must lie outside the data window.
- `XFER_SIZE`, default 32: record size in bytes. Must be a multiple of 8 and at least 8.
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `axi_req_i`  in  `ariane_axi::req_t`  AXI4 request, 64-bit data.
- `axi_resp_o`  out  `ariane_axi::resp_t`  AXI4 response.
- `msg_o`  out  `XFER_SIZE*8`  published record; word 0 is in the LSBs.
- `msg_valid_o`  out  1  a record is pending.
- `msg_ready_i`  in  1  the consumer accepts the record.
- `irq_o`  out  1  level interrupt, equal to `msg_valid_o`.

## Operation
- **Data buffer:** `XFER_SIZE/8` words of 64 bits, byte-strobed.
  - Word index is `(addr - MAILBOX_ADDR) >> 3`; the low 3 address bits are ignored.
  - The buffer is separate from the `msg_o` register, so the next record can be written while the current one is still pending.
- **Write FSM states:** W_IDLE, W_DATA, W_DB_WAIT, W_RESP, W_DRAIN.
  - W_IDLE: `aw_ready`=1. On AW handshake, latch id, addr, len and atop, then go to W_DATA.
  - W_DATA: `w_ready`=1.
    - If the latched len≠0 or atop≠0: go to W_DRAIN with resp SLVERR.
    - Else, data-window hit: write the strobed bytes, resp OKAY, go to W_RESP.
    - Else, doorbell hit with any strobe set: if `msg_valid_o`=0, copy the buffer to `msg_o`, set `msg_valid_o`, go to W_RESP. Otherwise go to W_DB_WAIT.
    - Else, doorbell hit with all strobes 0: resp OKAY, no effect, go to W_RESP.
    - Else, no address hit: resp DECERR, go to W_RESP.
  - W_DRAIN: `w_ready`=1. Data is discarded. On the beat with `w.last`, go to W_RESP.
  - W_DB_WAIT: on `msg_valid_o && msg_ready_i`, reload `msg_o` from the buffer, keep `msg_valid_o`=1, go to W_RESP.
  - W_RESP: `b_valid`=1 with the latched id and resp. On `b_ready`, go to W_IDLE.
- **Read FSM states:** R_IDLE, R_RESP.
  - R_IDLE: `ar_ready`=1. On AR handshake, compute rdata, resp and id, then go to R_RESP.
    - Data window: rdata is the buffer word, resp OKAY.
    - Doorbell: rdata is `{63'b0, msg_valid_o}`, resp OKAY.
    - No address hit: rdata 0, resp DECERR.
    - Any AR with len≠0: resp SLVERR with a single beat.
  - R_RESP: `r_valid`=1, `r_last`=1. On `r_ready`, go to R_IDLE.
  - Read and write FSMs run independently.
- **Message port:** `msg_valid_o` clears on `msg_valid_o && msg_ready_i`, unless a reload happens in the same cycle.

## Timing
- Reset (`rst_ni`=0 at a clock edge):
  - Both FSMs return to their idle states.
  - Buffer, `msg_o`, `msg_valid_o` and `irq_o` are cleared to 0.
  - All AXI valid and ready outputs are 0 while `rst_ni`=0.
  - Reset mid-transaction drops the transaction; no response is issued.
- Write path:
  - AW handshake at cycle N gives `w_ready` at N+1.
  - W handshake at N+1 makes the buffer update visible at N+2, with `b_valid` at N+2. Best-case throughput is one write per 3 cycles.
  - Doorbell W handshake at cycle N with no record pending gives `msg_valid_o`=1 and `b_valid`=1 at N+1.
- Read path: AR handshake at cycle N gives `r_valid` at N+1.
- Same-cycle AR and W to the same word: the read returns the old value.
- Consumer handshake at cycle M while in W_DB_WAIT: at M+1 `msg_o` holds the new record, `msg_valid_o`=1 and `b_valid`=1.
- `aw_ready`, `w_ready` and `ar_ready` depend only on FSM state, never combinationally on request valids.

## Structure
- Add `cfi_mbox_wstate_e` and `cfi_mbox_rstate_e` to `ariane_pkg`, next to `cfi_log_t`.
- Mailbox address defaults are shared with the CFI stage parameters.
- One sub-module, `cfi_mailbox_buffer`: the strobed word array with one write port, one read port and a flat-vector output.

## Test plan
- Four single-beat writes of 'h1111…1111 to 'h4444…4444 at words 0–3, then a doorbell write of 1 -> `msg_o` = {4444…, 3333…, 2222…, 1111…}, `msg_valid_o`=`irq_o`=1 one cycle after the W handshake; all B resps OKAY.
- Second record written plus doorbell while the first is unconsumed, with `msg_ready_i` held low 20 cycles -> no `b_valid` for the doorbell during those cycles; `msg_ready_i` pulse -> `msg_o` is the second record the next cycle, and `b_valid` follows.
- Write to word 1 with strobe 'h0F and data 'hAABBCCDD_EEFF0011 over 'h0 -> read-back of word 1 returns 'h00000000_EEFF0011.
- Read of 'h10405000 -> DECERR with rdata 0; write with len=3 -> 4 beats accepted and one SLVERR B; AW with atop≠0 -> SLVERR; buffer unchanged in each case.
- Assert `rst_ni`=0 during W_DB_WAIT -> next cycle `msg_valid_o`=0, `irq_o`=0, no B response; the next write completes normally.
